game_timer_scheduler: RTL and testbench

Game-time base and professor-quiz scheduler for the game state machine. It divides Clk down to a minutes counter and decides when the professor appears, raising a quiz request. It also enforces the quiz answer window and flags game-time expiry. Its minutes/professor outputs drive the game FSM, which reports back whether it is in a quiz.

---
 rtl/game_timer_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_game_timer_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_scheduler.sv
// Game-minute time base and professor quiz scheduler for the game FSM.
// Optional: define SCHED_JITTER_EN to add 0..3 LFSR minutes to quiz spacing.
module game_timer_scheduler #(
    parameter int TICKS_PER_MIN = 100000000,
    parameter int MAX_TIME      = 120,
    parameter int QUIZ_PERIOD   = 16,
    parameter int QUIZ_WINDOW   = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic       run,
    input  logic       in_quiz,
    output logic [7:0] minutes,
    output logic       tick,
    output logic       professor,
    output logic       quiz_timeout,
    output logic       time_up,
    output logic [2:0] sched_state
);

    localparam int PW = $clog2(TICKS_PER_MIN);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MIN - 1);
    localparam logic [8:0] PERIOD9 = 9'(QUIZ_PERIOD);
    localparam logic [8:0] WINDOW9 = 9'(QUIZ_WINDOW);
    localparam logic [8:0] MAXT9 =
        (MAX_TIME > 511) ? 9'h1FF : 9'(MAX_TIME);
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_STOPPED  = 3'd0,
        ST_RUNNING  = 3'd1,
        ST_PROF_REQ = 3'd2,
        ST_QUIZ     = 3'd3,
        ST_EXPIRED  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    minutes_q, minutes_d;
    logic [7:0]    next_quiz_q, next_quiz_d;
    logic [7:0]    deadline_q, deadline_d;
    logic          fired_q, fired_d;
    logic          tick_q, tick_d;
    logic          prof_q, prof_d;
    logic          qto_q, qto_d;

    logic          counting;
    logic          wrap;
    logic          time_up_w;
    logic [1:0]    jit_run;
    logic [1:0]    jit_start;
    logic [8:0]    win_sum;
    logic [8:0]    per_sum;
    logic [8:0]    start_sum;
    logic [8:0]    inc_sum;

    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

`ifdef SCHED_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign jit_run   = lfsr_q[1:0];
    assign jit_start = LFSR_SEED[1:0];

    // LFSR steps once per game minute; Start restarts the sequence.
    always_comb begin
        lfsr_d = lfsr_q;
        if (Start) begin
            lfsr_d = LFSR_SEED;
        end else if (wrap) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end
    end

    // LFSR register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign jit_run   = 2'd0;
    assign jit_start = 2'd0;
`endif

    assign time_up_w = {1'b0, minutes_q} >= MAXT9;

    assign counting = run &&
                      (state_q == ST_RUNNING ||
                       state_q == ST_PROF_REQ ||
                       state_q == ST_QUIZ);

    assign wrap = counting && (presc_q == PRESC_MAX);

    assign win_sum   = {1'b0, minutes_q} + WINDOW9;
    assign per_sum   = {1'b0, minutes_q} + PERIOD9 + {7'd0, jit_run};
    assign start_sum = PERIOD9 + {7'd0, jit_start};
    assign inc_sum   = {1'b0, minutes_q} + 9'd1;

    // Next-state: Start first, then prescaler, then scheduler decisions
    // made on pre-increment minutes.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        minutes_d   = minutes_q;
        next_quiz_d = next_quiz_q;
        deadline_d  = deadline_q;
        fired_d     = fired_q;
        tick_d      = 1'b0;
        qto_d       = 1'b0;

        if (Start) begin
            presc_d     = '0;
            minutes_d   = 8'd0;
            next_quiz_d = sat8(start_sum);
            fired_d     = 1'b0;
            state_d     = ST_RUNNING;
        end else begin
            if (wrap) begin
                presc_d   = '0;
                minutes_d = sat8(inc_sum);
                tick_d    = 1'b1;
            end else if (counting) begin
                presc_d = presc_q + PW'(1);
            end

            unique case (state_q)
                ST_STOPPED: begin
                    state_d = ST_STOPPED;
                end
                ST_RUNNING: begin
                    if (time_up_w) begin
                        state_d = ST_EXPIRED;
                    end else if (minutes_q >= next_quiz_q) begin
                        state_d = ST_PROF_REQ;
                    end else if (in_quiz) begin
                        deadline_d = sat8(win_sum);
                        fired_d    = 1'b0;
                        state_d    = ST_QUIZ;
                    end
                end
                ST_PROF_REQ: begin
                    if (in_quiz) begin
                        deadline_d = sat8(win_sum);
                        fired_d    = 1'b0;
                        state_d    = ST_QUIZ;
                    end
                end
                ST_QUIZ: begin
                    if (!in_quiz) begin
                        next_quiz_d = sat8(per_sum);
                        fired_d     = 1'b0;
                        state_d     = ST_RUNNING;
                    end else if (!fired_q &&
                                 minutes_q >= deadline_q) begin
                        qto_d   = 1'b1;
                        fired_d = 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    if (Ack) begin
                        state_d = ST_STOPPED;
                    end
                end
                default: begin
                    state_d = ST_STOPPED;
                end
            endcase
        end

        prof_d = (state_d == ST_PROF_REQ);
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_STOPPED;
            presc_q     <= '0;
            minutes_q   <= 8'd0;
            next_quiz_q <= PERIOD9[7:0];
            deadline_q  <= 8'd0;
            fired_q     <= 1'b0;
            tick_q      <= 1'b0;
            prof_q      <= 1'b0;
            qto_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            minutes_q   <= minutes_d;
            next_quiz_q <= next_quiz_d;
            deadline_q  <= deadline_d;
            fired_q     <= fired_d;
            tick_q      <= tick_d;
            prof_q      <= prof_d;
            qto_q       <= qto_d;
        end
    end

    assign minutes      = minutes_q;
    assign tick         = tick_q;
    assign professor    = prof_q;
    assign quiz_timeout = qto_q;
    assign time_up      = time_up_w;
    assign sched_state  = state_q;

endmodule

// File: tb/tb_game_timer_scheduler.sv
// Bench for game_timer_scheduler: directed scenarios plus a randomized
// run against a cycle-count reference model.
module tb_game_timer_scheduler;

    localparam int TPM = 4;
    localparam int MAXT = 120;
    localparam int PER = 16;
    localparam int WIN = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic       run = 1'b0;
    logic       in_quiz = 1'b0;
    logic [7:0] minutes;
    logic       tick;
    logic       professor;
    logic       quiz_timeout;
    logic       time_up;
    logic [2:0] sched_state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: minutes derived from active cycles since Start.
    int m_st, m_act, m_nq, m_dl;
    bit m_fired, m_tick, m_prof, m_qto;
    int n_st, n_act, n_nq, n_dl;
    bit n_fired, n_tick, n_prof, n_qto;

    game_timer_scheduler #(
        .TICKS_PER_MIN(TPM),
        .MAX_TIME(MAXT),
        .QUIZ_PERIOD(PER),
        .QUIZ_WINDOW(WIN)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Ack(Ack),
        .run(run),
        .in_quiz(in_quiz),
        .minutes(minutes),
        .tick(tick),
        .professor(professor),
        .quiz_timeout(quiz_timeout),
        .time_up(time_up),
        .sched_state(sched_state)
    );

    always #5 Clk = ~Clk;

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int m_min();
        return min255(m_act / TPM);
    endfunction

    task automatic m_reset();
        m_st = 0; m_act = 0; m_nq = PER; m_dl = 0;
        m_fired = 0; m_tick = 0; m_prof = 0; m_qto = 0;
    endtask

    task automatic m_step();
        int mins;
        bit tu;
        mins = m_min();
        tu = (mins >= MAXT);
        n_st = m_st; n_act = m_act; n_nq = m_nq; n_dl = m_dl;
        n_fired = m_fired; n_tick = 0; n_qto = 0;
        if (Start) begin
            n_act = 0; n_nq = PER; n_st = 1; n_fired = 0;
        end else begin
            if (run && m_st >= 1 && m_st <= 3) begin
                n_act = m_act + 1;
                n_tick = ((n_act % TPM) == 0);
            end
            case (m_st)
                1: begin
                    if (tu) n_st = 4;
                    else if (mins >= m_nq) n_st = 2;
                    else if (in_quiz) begin
                        n_dl = min255(mins + WIN); n_fired = 0; n_st = 3;
                    end
                end
                2: begin
                    if (in_quiz) begin
                        n_dl = min255(mins + WIN); n_fired = 0; n_st = 3;
                    end
                end
                3: begin
                    if (!in_quiz) begin
                        n_nq = min255(mins + PER); n_fired = 0; n_st = 1;
                    end else if (!m_fired && mins >= m_dl) begin
                        n_qto = 1; n_fired = 1;
                    end
                end
                4: if (Ack) n_st = 0;
                default: n_st = 0;
            endcase
        end
        n_prof = (n_st == 2);
    endtask

    task automatic cyc();
        m_step();
        @(posedge Clk);
        #1;
        m_st = n_st; m_act = n_act; m_nq = n_nq; m_dl = n_dl;
        m_fired = n_fired; m_tick = n_tick; m_prof = n_prof; m_qto = n_qto;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        Start = 0; Ack = 0; run = 0; in_quiz = 0;
        m_reset();
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        n_vec++;
        if ({minutes, tick, professor, quiz_timeout, time_up, sched_state}
            !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got m=%0d t=%b p=%b q=%b u=%b s=%0d want all 0",
                     minutes, tick, professor, quiz_timeout, time_up, sched_state);
        end
        Reset = 1'b0;
        m_reset();
    endtask

    task automatic test_minutes();
        int last, ticks;
        pulse_start();
        run = 1'b1;
        n_vec++;
        if (sched_state !== 3'd1 || minutes !== 8'd0 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL start_state: got s=%0d m=%0d t=%b want s=1 m=0 t=0",
                     sched_state, minutes, tick);
        end
        last = -1;
        ticks = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            n_vec++;
            if (tick !== ((k % 4) == 0)) begin
                n_err++;
                $display("FAIL tick_cycle%0d: got %b want %b", k, tick, (k % 4) == 0);
            end
            if (tick === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (k - last != 4) begin
                        n_err++;
                        $display("FAIL tick_spacing: got %0d want 4", k - last);
                    end
                end
                last = k;
                ticks++;
            end
        end
        n_vec++;
        if (minutes !== 8'd10 || ticks != 10) begin
            n_err++;
            $display("FAIL minutes_after40: got m=%0d ticks=%0d want m=10 ticks=10",
                     minutes, ticks);
        end
    endtask

    task automatic test_professor();
        int i;
        for (i = 0; i < 400 && minutes !== 8'd16; i++) cyc();
        n_vec++;
        if (minutes !== 8'd16 || sched_state !== 3'd1 || professor !== 1'b0) begin
            n_err++;
            $display("FAIL reach16: got m=%0d s=%0d p=%b want m=16 s=1 p=0",
                     minutes, sched_state, professor);
        end
        cyc();
        n_vec++;
        if (sched_state !== 3'd2 || professor !== 1'b1) begin
            n_err++;
            $display("FAIL prof_req: got s=%0d p=%b want s=2 p=1",
                     sched_state, professor);
        end
        in_quiz = 1'b1;
        cyc();
        n_vec++;
        if (sched_state !== 3'd3 || professor !== 1'b0 || minutes !== 8'd16) begin
            n_err++;
            $display("FAIL enter_quiz: got s=%0d p=%b m=%0d want s=3 p=0 m=16",
                     sched_state, professor, minutes);
        end
    endtask

    task automatic test_quiz_timeout();
        int i, pulses, pmin;
        pulses = 0;
        pmin = -1;
        for (i = 0; i < 200 && minutes !== 8'd21; i++) begin
            cyc();
            if (quiz_timeout === 1'b1) begin
                pulses++;
                pmin = minutes;
            end
        end
        n_vec++;
        if (minutes !== 8'd21 || pulses != 1 || pmin != 19) begin
            n_err++;
            $display("FAIL quiz_timeout: got m=%0d pulses=%0d at=%0d want m=21 pulses=1 at=19",
                     minutes, pulses, pmin);
        end
        in_quiz = 1'b0;
        cyc();
        n_vec++;
        if (sched_state !== 3'd1) begin
            n_err++;
            $display("FAIL quiz_exit: got s=%0d want 1", sched_state);
        end
        for (i = 0; i < 400 && sched_state !== 3'd2; i++) cyc();
        n_vec++;
        if (sched_state !== 3'd2 || minutes !== 8'd37) begin
            n_err++;
            $display("FAIL next_prof: got s=%0d m=%0d want s=2 m=37",
                     sched_state, minutes);
        end
    endtask

    task automatic test_pause();
        int bad;
        do_reset();
        pulse_start();
        run = 1'b1;
        repeat (6) cyc();
        n_vec++;
        if (minutes !== 8'd1) begin
            n_err++;
            $display("FAIL pause_pre: got m=%0d want 1", minutes);
        end
        run = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (tick !== 1'b0 || minutes !== 8'd1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL pause_hold: got %0d bad cycles want 0", bad);
        end
        run = 1'b1;
        cyc();
        n_vec++;
        if (tick !== 1'b0 || minutes !== 8'd1) begin
            n_err++;
            $display("FAIL resume1: got t=%b m=%0d want t=0 m=1", tick, minutes);
        end
        cyc();
        n_vec++;
        if (tick !== 1'b1 || minutes !== 8'd2) begin
            n_err++;
            $display("FAIL resume2: got t=%b m=%0d want t=1 m=2", tick, minutes);
        end
    endtask

    task automatic run_to_expiry(output bit ok);
        int i;
        run = 1'b1;
        in_quiz = 1'b0;
        for (i = 0; i < 3000 && sched_state !== 3'd4; i++) begin
            cyc();
            if (professor === 1'b1) in_quiz = 1'b1;
            else if (sched_state === 3'd3) in_quiz = 1'b0;
        end
        in_quiz = 1'b0;
        ok = (sched_state === 3'd4);
    endtask

    task automatic test_expire();
        bit ok;
        int bad;
        do_reset();
        pulse_start();
        run_to_expiry(ok);
        n_vec++;
        if (!ok || minutes !== 8'd120 || time_up !== 1'b1) begin
            n_err++;
            $display("FAIL expire: got s=%0d m=%0d u=%b want s=4 m=120 u=1",
                     sched_state, minutes, time_up);
        end
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (minutes !== 8'd120 || sched_state !== 3'd4) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL expire_frozen: got %0d bad cycles want 0", bad);
        end
        Start = 1'b1;
        Ack = 1'b1;
        cyc();
        Start = 1'b0;
        Ack = 1'b0;
        n_vec++;
        if (sched_state !== 3'd1 || minutes !== 8'd0) begin
            n_err++;
            $display("FAIL start_ack: got s=%0d m=%0d want s=1 m=0",
                     sched_state, minutes);
        end
        run_to_expiry(ok);
        Ack = 1'b1;
        cyc();
        Ack = 1'b0;
        n_vec++;
        if (!ok || sched_state !== 3'd0 || minutes !== 8'd120) begin
            n_err++;
            $display("FAIL ack: got s=%0d m=%0d want s=0 m=120",
                     sched_state, minutes);
        end
    endtask

    task automatic test_reset_quiz();
        int i;
        do_reset();
        pulse_start();
        run = 1'b1;
        for (i = 0; i < 400 && professor !== 1'b1; i++) cyc();
        in_quiz = 1'b1;
        for (i = 0; i < 400 && quiz_timeout !== 1'b1; i++) cyc();
        n_vec++;
        if (quiz_timeout !== 1'b1 || sched_state !== 3'd3) begin
            n_err++;
            $display("FAIL reset_quiz_setup: got q=%b s=%0d want q=1 s=3",
                     quiz_timeout, sched_state);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_vec++;
        if (minutes !== 8'd0 || professor !== 1'b0 ||
            quiz_timeout !== 1'b0 || sched_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_quiz: got m=%0d p=%b q=%b s=%0d want 0 0 0 0",
                     minutes, professor, quiz_timeout, sched_state);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        run = 1'b0;
        in_quiz = 1'b0;
        m_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 4000; it++) begin
            Start = (it == 0) || ($urandom_range(0, 899) == 0);
            Ack = ($urandom_range(0, 15) == 0);
            run = ($urandom_range(0, 7) != 0);
            if (!in_quiz)
                in_quiz = professor ? ($urandom_range(0, 1) == 1)
                                    : ($urandom_range(0, 99) == 0);
            else
                in_quiz = ($urandom_range(0, 19) != 0);
            cyc();
            n_vec++;
            if (minutes !== 8'(m_min())) begin
                n_err++;
                $display("FAIL rnd_minutes@%0d: got %0d want %0d", it, minutes, m_min());
            end
            n_vec++;
            if (tick !== m_tick) begin
                n_err++;
                $display("FAIL rnd_tick@%0d: got %b want %b", it, tick, m_tick);
            end
            n_vec++;
            if (professor !== m_prof) begin
                n_err++;
                $display("FAIL rnd_prof@%0d: got %b want %b", it, professor, m_prof);
            end
            n_vec++;
            if (quiz_timeout !== m_qto) begin
                n_err++;
                $display("FAIL rnd_qto@%0d: got %b want %b", it, quiz_timeout, m_qto);
            end
            n_vec++;
            if (time_up !== (m_min() >= MAXT)) begin
                n_err++;
                $display("FAIL rnd_timeup@%0d: got %b want %b", it, time_up, m_min() >= MAXT);
            end
            n_vec++;
            if (sched_state !== 3'(m_st)) begin
                n_err++;
                $display("FAIL rnd_state@%0d: got %0d want %0d", it, sched_state, m_st);
            end
        end
        Start = 0; Ack = 0; run = 0; in_quiz = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_minutes();
        test_professor();
        test_quiz_timeout();
        test_pause();
        test_expire();
        test_reset_quiz();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
